execute_stage: RTL and testbench

//  Pipeline execute stage. Sits between decode and memory stages.

---
 rtl/execute_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: alu, branch/jump resolution, and the registered
// hand-off to the memory stage with a one-cycle fetch redirect.
package exe_pkg;
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SLL   = 5'd1,
    ALU_SLT   = 5'd2,
    ALU_SLTU  = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SRL   = 5'd5,
    ALU_OR    = 5'd6,
    ALU_AND   = 5'd7,
    ALU_PASS2 = 5'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    S1_REG  = 3'd0,
    S1_PC   = 3'd1,
    S1_ZERO = 3'd2
  } src1_e;

  typedef enum logic [2:0] {
    S2_REG  = 3'd0,
    S2_IMM  = 3'd1,
    S2_FOUR = 3'd2
  } src2_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JUMP = 3'd7
  } br_e;
endpackage

module alu
  import exe_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [XLEN-1:0] imm_value,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      alu_op,
  input  logic            sub_sra,
  input  logic [2:0]      src1,
  input  logic [2:0]      src2,
  output logic [XLEN-1:0] result,
  output logic            non_zero
);
  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0]        op1;
  logic [XLEN-1:0]        op2;
  logic signed [XLEN-1:0] sop1;
  logic signed [XLEN-1:0] sop2;
  logic [SW-1:0]          shamt;

  always_comb begin
    op1 = '0;
    case (src1)
      S1_REG:  op1 = rs1_value;
      S1_PC:   op1 = pc;
      default: op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    case (src2)
      S2_REG:  op2 = rs2_value;
      S2_IMM:  op2 = imm_value;
      S2_FOUR: op2 = XLEN'(4);
      default: op2 = '0;
    endcase
  end

  assign sop1  = op1;
  assign sop2  = op2;
  assign shamt = op2[SW-1:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:   result = sub_sra ? op1 - op2 : op1 + op2;
      ALU_SLL:   result = op1 << shamt;
      ALU_SLT:   result = XLEN'(sop1 < sop2);
      ALU_SLTU:  result = XLEN'(op1 < op2);
      ALU_XOR:   result = op1 ^ op2;
      ALU_SRL:   result = sub_sra ? $unsigned(sop1 >>> shamt)
                                  : op1 >> shamt;
      ALU_OR:    result = op1 | op2;
      ALU_AND:   result = op1 & op2;
      ALU_PASS2: result = op2;
      default:   result = '0;
    endcase
  end

  assign non_zero = |result;
endmodule

module execute_stage
  import exe_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic [XLEN-1:0] imm_value_in,
  input  logic [4:0]      alu_op_in,
  input  logic            sub_sra_in,
  input  logic [2:0]      src1_in,
  input  logic [2:0]      src2_in,
  input  logic [2:0]      branch_type_in,
  input  logic            jalr_in,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [2:0]      mem_funct3_in,
  input  logic            ready_in,
  output logic            valid_out,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic [2:0]      mem_funct3_out,
  output logic            redirect_valid_out,
  output logic [XLEN-1:0] redirect_target_out
);
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            rd_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_funct3;
  } ex_mem_t;

  ex_mem_t         ex_d;
  ex_mem_t         ex_q;
  logic            valid_q;
  logic            redir_q;
  logic [XLEN-1:0] target_q;

  logic [XLEN-1:0] alu_result;
  logic            alu_nz;
  logic            accept;
  logic            take;
  logic            taken;
  logic            is_jump;
  logic            is_branch;
  logic [XLEN-1:0] tgt_base;
  logic [XLEN-1:0] tgt_sum;
  logic [XLEN-1:0] target;

  alu #(.XLEN(XLEN)) u_alu (
    .rs1_value (rs1_value_in),
    .rs2_value (rs2_value_in),
    .imm_value (imm_value_in),
    .pc        (pc_in),
    .alu_op    (alu_op_in),
    .sub_sra   (sub_sra_in),
    .src1      (src1_in),
    .src2      (src2_in),
    .result    (alu_result),
    .non_zero  (alu_nz)
  );

  assign ready_out = !valid_q || ready_in;
  assign accept    = valid_in && ready_out;
  // wrong-path entries behind a live redirect are consumed but dropped
  assign take      = accept && !flush_in && !redir_q;

  assign is_jump   = branch_type_in == BR_JUMP;
  assign is_branch = branch_type_in != BR_NONE && !is_jump;

  always_comb begin
    taken = 1'b0;
    case (branch_type_in)
      BR_BEQ:  taken = !alu_nz;
      BR_BNE:  taken = alu_nz;
      BR_BLT:  taken = alu_result[0];
      BR_BGE:  taken = !alu_result[0];
      BR_BLTU: taken = alu_result[0];
      BR_BGEU: taken = !alu_result[0];
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign tgt_base = (is_jump && jalr_in) ? rs1_value_in : pc_in;
  assign tgt_sum  = tgt_base + imm_value_in;
  assign target   = {tgt_sum[XLEN-1:1], tgt_sum[0] & !is_jump};

  always_comb begin
    ex_d            = '0;
    ex_d.result     = alu_result;
    ex_d.store_data = rs2_value_in;
    ex_d.rd         = rd_in;
    ex_d.rd_write   = rd_write_in && (rd_in != 5'd0) && !is_branch;
    ex_d.mem_read   = mem_read_in && !is_branch;
    ex_d.mem_write  = mem_write_in && !is_branch;
    ex_d.mem_funct3 = is_branch ? 3'd0 : mem_funct3_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      redir_q  <= 1'b0;
      target_q <= RESET_PC;
      ex_q     <= '0;
    end else begin
      redir_q <= 1'b0;
      if (flush_in) begin
        valid_q <= 1'b0;
      end else if (take) begin
        valid_q <= 1'b1;
        redir_q <= taken;
        ex_q    <= ex_d;
        if (taken)
          target_q <= target;
      end else if (accept || ready_in) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_out           = valid_q;
  assign result_out          = ex_q.result;
  assign store_data_out      = ex_q.store_data;
  assign rd_out              = ex_q.rd;
  assign rd_write_out        = ex_q.rd_write;
  assign mem_read_out        = ex_q.mem_read;
  assign mem_write_out       = ex_q.mem_write;
  assign mem_funct3_out      = ex_q.mem_funct3;
  assign redirect_valid_out  = redir_q;
  assign redirect_target_out = target_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: handshake, branches, jumps,
// stalls, flush and reset, with hand-computed expectations.
module tb_execute_stage;
  import exe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush_in;
  logic        valid_in;
  logic        ready_out;
  logic [63:0] pc_in;
  logic [63:0] rs1_value_in;
  logic [63:0] rs2_value_in;
  logic [63:0] imm_value_in;
  logic [4:0]  alu_op_in;
  logic        sub_sra_in;
  logic [2:0]  src1_in;
  logic [2:0]  src2_in;
  logic [2:0]  branch_type_in;
  logic        jalr_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  mem_funct3_in;
  logic        ready_in;
  logic        valid_out;
  logic [63:0] result_out;
  logic [63:0] store_data_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [2:0]  mem_funct3_out;
  logic        redirect_valid_out;
  logic [63:0] redirect_target_out;

  int n_cmp;
  int n_bad;

  execute_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_in            (flush_in),
    .valid_in            (valid_in),
    .ready_out           (ready_out),
    .pc_in               (pc_in),
    .rs1_value_in        (rs1_value_in),
    .rs2_value_in        (rs2_value_in),
    .imm_value_in        (imm_value_in),
    .alu_op_in           (alu_op_in),
    .sub_sra_in          (sub_sra_in),
    .src1_in             (src1_in),
    .src2_in             (src2_in),
    .branch_type_in      (branch_type_in),
    .jalr_in             (jalr_in),
    .rd_in               (rd_in),
    .rd_write_in         (rd_write_in),
    .mem_read_in         (mem_read_in),
    .mem_write_in        (mem_write_in),
    .mem_funct3_in       (mem_funct3_in),
    .ready_in            (ready_in),
    .valid_out           (valid_out),
    .result_out          (result_out),
    .store_data_out      (store_data_out),
    .rd_out              (rd_out),
    .rd_write_out        (rd_write_out),
    .mem_read_out        (mem_read_out),
    .mem_write_out       (mem_write_out),
    .mem_funct3_out      (mem_funct3_out),
    .redirect_valid_out  (redirect_valid_out),
    .redirect_target_out (redirect_target_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    valid_in       = 1'b0;
    pc_in          = '0;
    rs1_value_in   = '0;
    rs2_value_in   = '0;
    imm_value_in   = '0;
    alu_op_in      = ALU_ADD;
    sub_sra_in     = 1'b0;
    src1_in        = S1_REG;
    src2_in        = S2_REG;
    branch_type_in = BR_NONE;
    jalr_in        = 1'b0;
    rd_in          = '0;
    rd_write_in    = 1'b0;
    mem_read_in    = 1'b0;
    mem_write_in   = 1'b0;
    mem_funct3_in  = '0;
  endtask

  task automatic drive(input logic [63:0] pc,
                       input logic [63:0] rs1,
                       input logic [63:0] rs2,
                       input logic [63:0] imm,
                       input logic [4:0]  op,
                       input logic        sub,
                       input logic [2:0]  s1,
                       input logic [2:0]  s2,
                       input logic [2:0]  br,
                       input logic        jalr,
                       input logic [4:0]  rd,
                       input logic        rdw);
    clear();
    valid_in       = 1'b1;
    pc_in          = pc;
    rs1_value_in   = rs1;
    rs2_value_in   = rs2;
    imm_value_in   = imm;
    alu_op_in      = op;
    sub_sra_in     = sub;
    src1_in        = s1;
    src2_in        = s2;
    branch_type_in = br;
    jalr_in        = jalr;
    rd_in          = rd;
    rd_write_in    = rdw;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    flush_in = 1'b0;
    ready_in = 1'b1;
    drive(64'h0, 64'd5, 64'd7, 64'h0, ALU_ADD, 1'b0,
          S1_REG, S2_REG, BR_NONE, 1'b0, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_redir", redirect_valid_out, 0);
    check("rst_ready", ready_out, 1);
    check("rst_target", redirect_target_out, 64'h0);
    check("rst_rdw", rd_write_out, 0);

    rst_n = 1'b1;
    step();
    check("add_valid", valid_out, 1);
    check("add_result", result_out, 64'd12);
    check("add_rd", rd_out, 5'd3);
    check("add_rdw", rd_write_out, 1);
    check("add_redir", redirect_valid_out, 0);

    drive(64'h100, 64'd9, 64'd9, 64'h20, ALU_ADD, 1'b1,
          S1_REG, S2_REG, BR_BEQ, 1'b0, 5'd0, 1'b0);
    step();
    check("beq_valid", valid_out, 1);
    check("beq_redir", redirect_valid_out, 1);
    check("beq_target", redirect_target_out, 64'h120);
    check("beq_rdw", rd_write_out, 0);

    drive(64'h104, 64'd1, 64'd1, 64'h0, ALU_ADD, 1'b0,
          S1_REG, S2_REG, BR_NONE, 1'b0, 5'd4, 1'b1);
    #1;
    check("wp_ready", ready_out, 1);
    step();
    check("wp_valid", valid_out, 0);
    check("wp_redir", redirect_valid_out, 0);

    drive(64'h108, 64'd9, 64'd8, 64'h20, ALU_ADD, 1'b1,
          S1_REG, S2_REG, BR_BEQ, 1'b0, 5'd0, 1'b0);
    step();
    check("beq_nt_valid", valid_out, 1);
    check("beq_nt_redir", redirect_valid_out, 0);
    check("beq_nt_rdw", rd_write_out, 0);

    drive(64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'd2, 64'h20, ALU_ADD,
          1'b1, S1_REG, S2_REG, BR_BEQ, 1'b0, 5'd0, 1'b0);
    step();
    check("wrap_redir", redirect_valid_out, 1);
    check("wrap_target", redirect_target_out, 64'h10);
    clear();
    step();
    check("idle_valid", valid_out, 0);

    drive(64'h40, 64'h2003, 64'h0, 64'd4, ALU_ADD, 1'b0,
          S1_PC, S2_FOUR, BR_JUMP, 1'b1, 5'd1, 1'b1);
    step();
    check("jalr_redir", redirect_valid_out, 1);
    check("jalr_target", redirect_target_out, 64'h2006);
    check("jalr_link", result_out, 64'h44);
    check("jalr_rdw", rd_write_out, 1);
    clear();
    step();
    check("jalr_done", redirect_valid_out, 0);

    drive(64'h80, 64'h0, 64'h0, 64'h11, ALU_ADD, 1'b0,
          S1_PC, S2_FOUR, BR_JUMP, 1'b0, 5'd0, 1'b1);
    step();
    check("jal_target", redirect_target_out, 64'h90);
    check("jal_rd0_rdw", rd_write_out, 0);
    clear();
    step();

    drive(64'h0, 64'h1000, 64'hAB, 64'd8, ALU_ADD, 1'b0,
          S1_REG, S2_IMM, BR_NONE, 1'b0, 5'd5, 1'b1);
    mem_read_in   = 1'b1;
    mem_funct3_in = 3'd3;
    step();
    check("ld_addr", result_out, 64'h1008);
    check("ld_rd", mem_read_out, 1);
    check("ld_wr", mem_write_out, 0);
    check("ld_f3", mem_funct3_out, 3'd3);
    check("ld_sdata", store_data_out, 64'hAB);
    clear();
    step();

    ready_in = 1'b0;
    drive(64'h200, 64'd3, 64'd4, 64'h10, ALU_ADD, 1'b1,
          S1_REG, S2_REG, BR_BNE, 1'b0, 5'd0, 1'b0);
    step();
    check("bne_valid", valid_out, 1);
    check("bne_redir", redirect_valid_out, 1);
    check("bne_target", redirect_target_out, 64'h210);
    drive(64'h300, 64'd1, 64'd1, 64'h0, ALU_ADD, 1'b0,
          S1_REG, S2_REG, BR_NONE, 1'b0, 5'd6, 1'b1);
    #1;
    check("stall_ready", ready_out, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_valid", valid_out, 1);
      check("stall_redir", redirect_valid_out, 0);
      check("stall_result", result_out, 64'hFFFF_FFFF_FFFF_FFFF);
      check("stall_rd", rd_out, 5'd0);
      check("stall_target", redirect_target_out, 64'h210);
    end
    clear();
    ready_in = 1'b1;
    step();
    check("drain_valid", valid_out, 0);

    drive(64'h500, 64'd1, 64'd2, 64'h0, ALU_ADD, 1'b0,
          S1_REG, S2_REG, BR_NONE, 1'b0, 5'd7, 1'b1);
    flush_in = 1'b1;
    step();
    check("flush_valid", valid_out, 0);
    check("flush_redir", redirect_valid_out, 0);

    drive(64'h400, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8, ALU_SLT,
          1'b0, S1_REG, S2_REG, BR_BLT, 1'b0, 5'd0, 1'b0);
    step();
    check("blt_fl_valid", valid_out, 0);
    check("blt_fl_redir", redirect_valid_out, 0);
    flush_in = 1'b0;
    step();
    check("blt_redir", redirect_valid_out, 1);
    check("blt_target", redirect_target_out, 64'h408);
    clear();
    step();

    drive(64'h600, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8, ALU_SLTU,
          1'b0, S1_REG, S2_REG, BR_BLTU, 1'b0, 5'd0, 1'b0);
    step();
    check("bltu_valid", valid_out, 1);
    check("bltu_redir", redirect_valid_out, 0);
    drive(64'h700, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8, ALU_SLTU,
          1'b0, S1_REG, S2_REG, BR_BGEU, 1'b0, 5'd0, 1'b0);
    step();
    check("bgeu_redir", redirect_valid_out, 1);
    check("bgeu_target", redirect_target_out, 64'h708);
    clear();
    step();

    ready_in = 1'b0;
    drive(64'h800, 64'd1, 64'd1, 64'h0, ALU_ADD, 1'b0,
          S1_REG, S2_REG, BR_NONE, 1'b0, 5'd8, 1'b1);
    step();
    check("hold_valid", valid_out, 1);
    clear();
    flush_in = 1'b1;
    step();
    check("hold_flush", valid_out, 0);
    flush_in = 1'b0;

    drive(64'h900, 64'd1, 64'd1, 64'h0, ALU_ADD, 1'b0,
          S1_REG, S2_REG, BR_NONE, 1'b0, 5'd9, 1'b1);
    step();
    check("hold2_valid", valid_out, 1);
    clear();
    rst_n = 1'b0;
    step();
    check("midrst_valid", valid_out, 0);
    check("midrst_target", redirect_target_out, 64'h0);
    check("midrst_rd", rd_out, 5'd0);
    rst_n    = 1'b1;
    ready_in = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
